// File: rtl/fu_execute_bank.sv
// Three-lane execution bank: single-cycle ALU ops and two-cycle load/store
// address ops, each lane with its own ready bit and forwarding broadcast port.
module fu_execute_bank #(
  parameter int AR_SIZE  = 7,
  parameter int FU_ARRAY = 3,
  parameter int DATA_W   = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [FU_ARRAY-1:0]         issue_valid_in,
  input  logic [FU_ARRAY*4-1:0]       op_in,
  input  logic [FU_ARRAY*AR_SIZE-1:0] rd_in,
  input  logic [FU_ARRAY*DATA_W-1:0]  rs1_value_in,
  input  logic [FU_ARRAY*DATA_W-1:0]  rs2_value_in,
  input  logic [FU_ARRAY*DATA_W-1:0]  imm_value_in,
  output logic [FU_ARRAY-1:0]         fu_ready_out,
  output logic [FU_ARRAY-1:0]         fu_flag_out,
  output logic [FU_ARRAY*AR_SIZE-1:0] reg_tag_out,
  output logic [FU_ARRAY*DATA_W-1:0]  reg_value_out,
  output logic [FU_ARRAY-1:0]         issue_drop_out
);

  typedef enum logic {S_IDLE, S_MEM} lane_state_t;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRAI = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SW   = 4'd10;

  for (genvar g = 0; g < FU_ARRAY; g++) begin : g_lane
    lane_state_t          r_state, w_state_nxt;
    logic                 r_flag, w_flag_nxt;
    logic [AR_SIZE-1:0]   r_tag, w_tag_nxt;
    logic [DATA_W-1:0]    r_value, w_value_nxt;
    logic                 r_drop, w_drop_nxt;
    logic [AR_SIZE-1:0]   r_mem_rd;
    logic [DATA_W-1:0]    r_mem_addr;
    logic                 r_mem_load;

    logic [3:0]           w_op;
    logic [AR_SIZE-1:0]   w_rd;
    logic [DATA_W-1:0]    w_rs1, w_rs2, w_imm, w_alu, w_addr;
    logic                 w_is_alu, w_is_mem, w_is_load, w_accept;

    assign w_op   = op_in[4*g +: 4];
    assign w_rd   = rd_in[AR_SIZE*g +: AR_SIZE];
    assign w_rs1  = rs1_value_in[DATA_W*g +: DATA_W];
    assign w_rs2  = rs2_value_in[DATA_W*g +: DATA_W];
    assign w_imm  = imm_value_in[DATA_W*g +: DATA_W];
    assign w_addr = w_rs1 + w_imm;

    assign w_is_alu  = (w_op >= OP_ADD) && (w_op <= OP_SRAI);
    assign w_is_mem  = (w_op >= OP_LB)  && (w_op <= OP_SW);
    assign w_is_load = (w_op == OP_LB)  || (w_op == OP_LW);
    assign w_accept  = issue_valid_in[g] && (r_state == S_IDLE);

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
      w_alu = '0;
      case (w_op)
        OP_ADD:  w_alu = w_rs1 + w_rs2;
        OP_ADDI: w_alu = w_rs1 + w_imm;
        OP_LUI:  w_alu = w_imm;
        OP_ORI:  w_alu = w_rs1 | w_imm;
        OP_XOR:  w_alu = w_rs1 ^ w_imm;
        OP_SRAI: w_alu = $signed(w_rs1) >>> w_imm[4:0];
        default: w_alu = '0;
      endcase
    end

    // Tag/value only move when a broadcast is produced; otherwise they hold.
    always_comb begin
      w_state_nxt = r_state;
      w_flag_nxt  = 1'b0;
      w_tag_nxt   = r_tag;
      w_value_nxt = r_value;
      w_drop_nxt  = 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_alu && (w_rd != '0)) begin
            w_flag_nxt  = 1'b1;
            w_tag_nxt   = w_rd;
            w_value_nxt = w_alu;
          end
          if (w_accept && w_is_mem) w_state_nxt = S_MEM;
        end
        S_MEM: begin
          w_state_nxt = S_IDLE;
          w_drop_nxt  = issue_valid_in[g];
          if (r_mem_load && (r_mem_rd != '0)) begin
            w_flag_nxt  = 1'b1;
            w_tag_nxt   = r_mem_rd;
            w_value_nxt = r_mem_addr;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_state <= S_IDLE;
        r_flag  <= 1'b0;
        r_tag   <= '0;
        r_value <= '0;
        r_drop  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_flag  <= w_flag_nxt;
        r_tag   <= w_tag_nxt;
        r_value <= w_value_nxt;
        r_drop  <= w_drop_nxt;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_mem_rd   <= '0;
        r_mem_addr <= '0;
        r_mem_load <= 1'b0;
      end else if (w_accept && w_is_mem) begin
        r_mem_rd   <= w_rd;
        r_mem_addr <= w_addr;
        r_mem_load <= w_is_load;
      end
    end

    assign fu_ready_out[g]                     = (r_state == S_IDLE);
    assign fu_flag_out[g]                      = r_flag;
    assign reg_tag_out[AR_SIZE*g +: AR_SIZE]   = r_tag;
    assign reg_value_out[DATA_W*g +: DATA_W]   = r_value;
    assign issue_drop_out[g]                   = r_drop;
  end

endmodule

// File: doc/fu_execute_bank.md
Name: fu_execute_bank

Overview:
Three-lane execution bank on the issue side of the unified issue queue. It accepts up to three issued operations per cycle, one per FU tunnel, and computes each result. It drives back per-FU ready bits and the tag/value forwarding broadcasts that the issue queue snoops to wake up waiting sources. ALU ops take 1 cycle. Load/store address ops take 2 cycles and block their lane for one cycle.

Parameters:
AR_SIZE, 7, physical register tag width
FU_ARRAY, 3, number of FU lanes (fixed at 3; ports below are sized for 3)
DATA_W, 32, operand/result width

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
issue_valid_in  input  3  bit i = op presented on lane i this cycle
op_in  input  12  4-bit op code per lane, lane i at [4i+3:4i]; 1 ADD, 2 ADDI, 3 LUI, 4 ORI, 5 XOR(I), 6 SRAI, 7 LB, 8 LW, 9 SB, 10 SW
rd_in  input  3*AR_SIZE  destination tag per lane
rs1_value_in  input  96  source-1 value per lane, lane i at [32i+31:32i]
rs2_value_in  input  96  source-2 value per lane
imm_value_in  input  96  immediate per lane
fu_ready_out  output  3  bit i = lane i can accept this cycle
fu_flag_out  output  3  bit i = lane i broadcasting a result this cycle
reg_tag_out  output  3*AR_SIZE  broadcast tag per lane
reg_value_out  output  96  broadcast value per lane
issue_drop_out  output  3  bit i = issue to busy lane i was discarded (1-cycle pulse)

Behaviour:
- Reset: single clock; asynchronous active-low reset on rstn.
  - Every output except fu_ready_out clears to 0 immediately on rstn low.
  - fu_ready_out resets to 3'b111.
  - All lanes reset to IDLE.
  - Reset asserted mid-operation aborts the in-flight op; no flag is produced for it.
- Lanes are fully independent. Identical logic per lane i.
- Lane states: IDLE (ready) and MEM (busy). fu_ready_out[i] = 1 iff the lane is in IDLE, and it is a registered output.
- Accept: issue_valid_in[i] && fu_ready_out[i] at a rising edge.
- ALU ops (op 1..6):
  - Result is registered at the accept edge.
  - fu_flag_out[i] is high for exactly the following cycle, with reg_tag_out = rd and reg_value_out = result.
  - Lane stays IDLE, so back-to-back issue every cycle is legal.
- Results, all mod 2^32:
  - ADD = rs1 + rs2
  - ADDI = rs1 + imm
  - LUI = imm (imm arrives pre-shifted)
  - ORI = rs1 | imm
  - XOR = rs1 ^ imm
  - SRAI = rs1 arithmetically shifted right by imm[4:0]
- Memory ops (op 7..10):
  - At the accept edge the lane enters MEM and fu_ready_out[i] drops to 0.
  - Address = rs1 + imm, latched at accept.
  - At the next edge the lane returns to IDLE and fu_ready_out[i] goes back to 1.
  - For LB/LW, fu_flag_out[i] is high for the cycle after that edge, carrying rd and the address.
  - SB/SW never raise the flag.
- Op 0 or 11..15: accepted as a NOP. No flag, lane stays IDLE.
- rd == 0: the op executes but the flag is suppressed (p0 is never broadcast).
- Issue while busy: issue_valid_in[i] with fu_ready_out[i] = 0 discards the op, and issue_drop_out[i] pulses in the next cycle. The in-flight MEM op completes normally.
- When fu_flag_out[i] = 0: reg_tag_out and reg_value_out for that lane hold their last values; consumers must qualify them with the flag.
- Simultaneous completions on multiple lanes: all flags are asserted in the same cycle. There is no arbitration; each lane has its own broadcast port.

Test Plan:
- Reset → fu_ready_out=3'b111, all flags 0, tags 0, values 0. Assert rstn low while lane 1 is in MEM → fu_ready_out[1]=1 immediately, and no flag follows.
- Lane 0 ADD, rs1=0x7FFFFFFF, rs2=1, rd=5 → next cycle fu_flag_out[0]=1, tag 5, value 0x80000000; cycle after that, flag 0.
- Lane 2 SRAI, rs1=0x80000010, imm=4, rd=9 → value 0xF8000001. Lane 1 LUI with imm=0x12345000 in the same cycle → both flags high together, correct per-lane values.
- Lane 1 LW, rs1=0x100, imm=0xFFFFFFFC, rd=12 → fu_ready_out[1]=0 for one cycle, then flag with value 0x000000FC, tag 12. SW with the same operands → ready dips, no flag.
- Lane 1 LB followed immediately by ADD on lane 1 → ADD dropped, issue_drop_out[1] pulses once, LB flag still appears 2 cycles after accept.
- ADDI with rd=0, followed by op=0 → no flag for either; lane ready throughout.
